// File: rtl/nandn_pipe.sv
// Registered multi-operand bitwise reduction (NAND by default) behind a valid/ready pipeline.
// Stage 1 captures the combinational result; later stages shift result, err and valid together.
module nandn_pipe #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_IN  = 2,
  parameter int unsigned LATENCY = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [2:0]              i_mode,
  input  logic [NUM_IN*WIDTH-1:0] i_in1,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [WIDTH-1:0]        o_out,
  output logic                    o_err,
  output logic                    o_busy
);

  typedef enum logic [2:0] {
    ModeNand = 3'd0,
    ModeAnd  = 3'd1,
    ModeNor  = 3'd2,
    ModeOr   = 3'd3,
    ModeXor  = 3'd4,
    ModeXnor = 3'd5,
    ModeNot0 = 3'd6,
    ModeRsvd = 3'd7
  } mode_e;

  logic [WIDTH-1:0] w_op0;
  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_xor;
  logic [WIDTH-1:0] w_res;
  logic             w_err;
  logic             w_adv;

  logic [WIDTH-1:0]   r_res [LATENCY];
  logic [LATENCY-1:0] r_err;
  logic [LATENCY-1:0] r_vld;

  always_comb begin
    w_op0 = i_in1[WIDTH-1:0];
    w_and = w_op0;
    w_or  = w_op0;
    w_xor = w_op0;
    for (int unsigned k = 1; k < NUM_IN; k++) begin
      w_and = w_and & i_in1[k*WIDTH +: WIDTH];
      w_or  = w_or  | i_in1[k*WIDTH +: WIDTH];
      w_xor = w_xor ^ i_in1[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    unique case (mode_e'(i_mode))
      ModeNand: w_res = ~w_and;
      ModeAnd:  w_res = w_and;
      ModeNor:  w_res = ~w_or;
      ModeOr:   w_res = w_or;
      ModeXor:  w_res = w_xor;
      ModeXnor: w_res = ~w_xor;
      ModeNot0: w_res = ~w_op0;
      ModeRsvd: begin
        w_res = '0;
        w_err = 1'b1;
      end
    endcase
  end

  // Whole pipe moves in lockstep; bubbles are never collapsed.
  assign w_adv = !r_vld[LATENCY-1] || i_out_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld <= '0;
      r_err <= '0;
      for (int unsigned s = 0; s < LATENCY; s++) begin
        r_res[s] <= '0;
      end
    end else if (w_adv) begin
      r_vld[0] <= i_in_valid;
      r_err[0] <= w_err;
      r_res[0] <= w_res;
      for (int unsigned s = 1; s < LATENCY; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_err[s] <= r_err[s-1];
        r_res[s] <= r_res[s-1];
      end
    end
  end

  assign o_in_ready  = w_adv;
  assign o_out_valid = r_vld[LATENCY-1];
  assign o_out       = r_res[LATENCY-1];
  assign o_err       = r_err[LATENCY-1];
  assign o_busy      = |r_vld;

endmodule

// File: doc/nandn_pipe.md
Name: nandn_pipe

Overview:
- Parametrised, registered successor of the common two-input NAND cell.
- Applies a run-time-selected bitwise reduction (NAND default, plus AND/NOR/OR/XOR/XNOR/NOT) across NUM_IN operands of WIDTH bits.
- Result passes through a LATENCY-deep elastic pipeline with valid/ready handshakes on both sides.
- Lives in common_module as the shared registered logic primitive for datapath and control blocks.

Parameters:
WIDTH, 8, bits per operand and result
NUM_IN, 2, operand count, 2..8
LATENCY, 2, pipeline register stages, 1..4

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operand bundle valid
in_ready  out  1  block accepts the bundle this cycle
mode  in  3  operation, sampled with the bundle
in1  in  NUM_IN*WIDTH  operands; operand k = in1[k*WIDTH +: WIDTH]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out  out  WIDTH  result
err  out  1  reserved mode flag, travels with the result
busy  out  1  any stage holds valid data

Behaviour:
- Reset is asynchronous and active-high: the design has one clock, and reset is asynchronous and active-high (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed).
- While rst is high:
  - every stage valid bit = 0
  - out = 0, err = 0, out_valid = 0, busy = 0
  - in_ready = 1 (combinational, see below)
- Reset mid-operation discards all in-flight results. No output transaction completes in the cycle rst deasserts.
- Mode encoding (bitwise over all NUM_IN operands):
  - 0 = NAND (~&)
  - 1 = AND
  - 2 = NOR
  - 3 = OR
  - 4 = XOR
  - 5 = XNOR
  - 6 = ~operand0, other operands ignored
  - 7 = reserved: result 0, err = 1
- Result is computed combinationally from in1/mode and captured in stage 1. Stages 2..LATENCY are plain shift registers for result, err and valid.
- Advance condition:
  - advance = !out_valid || out_ready
  - in_ready = advance (combinational; no dependency on in_valid)
  - When advance = 1, every stage loads from its predecessor. Stage 1 loads valid = in_valid && in_ready.
  - When advance = 0, every stage holds.
- Bubbles are not collapsed: a pipeline holding bubbles still stalls whenever out_valid && !out_ready.
- Latency: a bundle accepted at edge N appears with out_valid = 1 after edge N+LATENCY-1, provided no stall. It is visible in the cycle after that edge.
- out and err are held stable while out_valid = 1 and out_ready = 0. A stall adds exactly the stalled cycles to latency.
- The output transaction completes on an edge where out_valid && out_ready. The next stage's content replaces it on the same edge, so full throughput is one result per cycle.
- Simultaneous events: input accept and output pop on the same edge are legal and lose nothing.
- in1/mode are don't-care when in_valid = 0. A bubble is loaded and out is unchanged apart from the shift.
- busy = OR of all stage valid bits.
- Width rules: no arithmetic; all operations are bitwise at WIDTH bits. NUM_IN = 2 with mode 0 reduces to out = ~(a & b).

Test Plan:
1. WIDTH=8, NUM_IN=2, LATENCY=2, out_ready=1: mode=0, operands 0xF0/0xCC -> out=0x3F, out_valid one cycle after accept.
2. Stream mode 0..7 back-to-back on 0xF0/0xCC -> results in order:
   - 0x3F, 0xC0, 0x03, 0xFC
   - 0x3C, 0xC3, 0x0F, 0x00 with err=1
   - no gaps, in_ready always 1
3. Hold out_ready=0 for 5 cycles after first result, stream 3 bundles -> out held at first value, in_ready=0 once pipe full, all 3 delivered in order after release, none dropped or duplicated.
4. NUM_IN=3: operands 0xFF/0x0F/0x3C, mode 4 -> out=0xCC; mode 0 -> 0xF3.
5. Assert rst asynchronously mid-stream with 2 results in flight -> out_valid=0, busy=0, out=0 immediately, before the next clock edge; post-reset first bundle returns a correct result.
6. LATENCY=1 and LATENCY=4 sweeps with random in_valid/out_ready:
   - scoreboard matches the reference bitwise model
   - latency equals LATENCY plus stall cycles
